// File: rtl/ofdm_symbol_scheduler.sv
// OFDM symbol scheduler: sequences NUM_PRE preamble symbols followed by a
// per-frame count of data symbols into a 304-to-16 serializer. Each
// accepted source word is held on ser_data until the serializer reports the
// symbol complete. The frame is aborted if the data source underruns.
module ofdm_symbol_scheduler #(
    parameter int SYM_W        = 304,
    parameter int NUM_PRE      = 2,
    parameter int UNDERRUN_LIM = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic [7:0]       num_data_syms,
    input  logic             pre_valid,
    input  logic [SYM_W-1:0] pre_data,
    output logic             pre_ready,
    input  logic             dat_valid,
    input  logic [SYM_W-1:0] dat_data,
    output logic             dat_ready,
    input  logic             ser_ready,
    input  logic             ser_done,
    output logic             ser_valid,
    output logic [SYM_W-1:0] ser_data,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [7:0]       sym_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRE_WAIT  = 3'd1;
    localparam logic [2:0] S_DAT_WAIT  = 3'd2;
    localparam logic [2:0] S_XMIT      = 3'd3;
    localparam logic [2:0] S_FRAME_END = 3'd4;

    localparam logic [3:0] PRE_TOTAL = 4'(NUM_PRE);
    localparam logic [7:0] WAIT_LAST = 8'(UNDERRUN_LIM - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [7:0]       r_num_data;
    logic [7:0]       r_dat_cnt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       r_sym_count;
    logic [3:0]       r_pre_cnt;
    logic             r_ser_valid;
    logic             r_abort;
    logic [SYM_W-1:0] r_ser_data;
    logic             w_pre_acc;
    logic             w_dat_acc;
    logic             w_underrun;
    logic             w_start;

    assign pre_ready  = (r_state == S_PRE_WAIT) && ser_ready;
    assign dat_ready  = (r_state == S_DAT_WAIT) && ser_ready;
    assign w_pre_acc  = pre_ready && pre_valid;
    assign w_dat_acc  = dat_ready && dat_valid;
    assign w_start    = (r_state == S_IDLE) && frame_start;
    // The underrun fires on the LIM-th consecutive-counted low cycle in DAT_WAIT.
    assign w_underrun = (r_state == S_DAT_WAIT) && !dat_valid && (r_wait_cnt == WAIT_LAST);

    assign ser_valid  = r_ser_valid;
    assign ser_data   = r_ser_data;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_FRAME_END);
    assign frame_err  = (r_state == S_FRAME_END) && r_abort;
    assign sym_count  = r_sym_count;

    // Next-state decode; preamble/data counters count accepted words, so the
    // decision at ser_done already includes the symbol just completed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (frame_start) w_next = S_PRE_WAIT;
            S_PRE_WAIT:  if (w_pre_acc) w_next = S_XMIT;
            S_DAT_WAIT: begin
                if (w_dat_acc)       w_next = S_XMIT;
                else if (w_underrun) w_next = S_FRAME_END;
            end
            S_XMIT: begin
                if (ser_done) begin
                    if (r_pre_cnt < PRE_TOTAL)       w_next = S_PRE_WAIT;
                    else if (r_dat_cnt < r_num_data) w_next = S_DAT_WAIT;
                    else                             w_next = S_FRAME_END;
                end
            end
            S_FRAME_END: w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Launch path: load the accepted word and pulse ser_valid for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ser_valid <= 1'b0;
            r_ser_data  <= '0;
        end else begin
            r_ser_valid <= w_pre_acc || w_dat_acc;
            if (w_pre_acc)      r_ser_data <= pre_data;
            else if (w_dat_acc) r_ser_data <= dat_data;
        end
    end

    // Frame bookkeeping: symbol counters, latched length and abort flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_data  <= '0;
            r_pre_cnt   <= '0;
            r_dat_cnt   <= '0;
            r_sym_count <= '0;
            r_abort     <= 1'b0;
        end else begin
            if (w_start) begin
                r_num_data  <= num_data_syms;
                r_pre_cnt   <= '0;
                r_dat_cnt   <= '0;
                r_sym_count <= '0;
                r_abort     <= 1'b0;
            end
            if (w_pre_acc) r_pre_cnt <= r_pre_cnt + 4'd1;
            if (w_dat_acc) r_dat_cnt <= r_dat_cnt + 8'd1;
            if ((r_state == S_XMIT) && ser_done) r_sym_count <= r_sym_count + 8'd1;
            if (w_underrun) r_abort <= 1'b1;
        end
    end

    // Underrun watchdog: counts DAT_WAIT cycles with dat_valid low, cleared on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if ((w_next == S_DAT_WAIT) && (r_state != S_DAT_WAIT)) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_DAT_WAIT) && !dat_valid) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Scoreboard bench for ofdm_symbol_scheduler: frame plans are turned into
// expected launch words and frame results up front; a monitor pops and
// compares whenever the scheduler launches a symbol or ends a frame.
module tb_ofdm_symbol_scheduler;

    localparam int SYM_W   = 304;
    localparam int NUM_PRE = 2;
    localparam int LIM     = 64;
    localparam int SER_LAT = 20;

    logic             clk;
    logic             reset_n;
    logic             frame_start;
    logic [7:0]       num_data_syms;
    logic             pre_valid;
    logic [SYM_W-1:0] pre_data;
    logic             pre_ready;
    logic             dat_valid;
    logic [SYM_W-1:0] dat_data;
    logic             dat_ready;
    logic             ser_ready;
    logic             ser_done;
    logic             ser_valid;
    logic [SYM_W-1:0] ser_data;
    logic             busy;
    logic             frame_done;
    logic             frame_err;
    logic [7:0]       sym_count;

    ofdm_symbol_scheduler #(
        .SYM_W        (SYM_W),
        .NUM_PRE      (NUM_PRE),
        .UNDERRUN_LIM (LIM)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .num_data_syms (num_data_syms),
        .pre_valid     (pre_valid),
        .pre_data      (pre_data),
        .pre_ready     (pre_ready),
        .dat_valid     (dat_valid),
        .dat_data      (dat_data),
        .dat_ready     (dat_ready),
        .ser_ready     (ser_ready),
        .ser_done      (ser_done),
        .ser_valid     (ser_valid),
        .ser_data      (ser_data),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .sym_count     (sym_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int launches_seen = 0;
    int stall_cfg = 0;
    int plan_gap [0:255];

    logic [SYM_W-1:0] exp_launch_q [$];
    int               exp_cnt_q    [$];
    bit               exp_err_q    [$];
    logic [SYM_W-1:0] pre_src_w    [$];
    int               pre_src_g    [$];
    logic [SYM_W-1:0] dat_src_w    [$];
    int               dat_src_g    [$];

    function automatic logic [SYM_W-1:0] rand_word();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        return t[SYM_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [SYM_W-1:0] act, input logic [SYM_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Preamble source: after the planned number of ready-but-idle cycles, presents its word.
    initial begin
        int cnt;
        bit hs;
        bit lowc;
        cnt = 0;
        pre_valid = 1'b0;
        pre_data = '0;
        forever begin
            @(negedge clk);
            hs   = pre_valid && pre_ready;
            lowc = pre_ready && !pre_valid;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cnt = 0;
                pre_valid = 1'b0;
                continue;
            end
            if (hs && pre_src_w.size() > 0) begin
                void'(pre_src_w.pop_front());
                void'(pre_src_g.pop_front());
                cnt = 0;
            end else if (lowc) begin
                cnt++;
            end
            if (pre_src_w.size() == 0) begin
                cnt = 0;
                pre_valid = 1'b0;
            end else begin
                pre_data  = pre_src_w[0];
                pre_valid = (cnt >= pre_src_g[0]);
            end
        end
    end

    // Data source: withholds each word for its planned number of waiting cycles.
    initial begin
        int cnt;
        bit hs;
        bit lowc;
        cnt = 0;
        dat_valid = 1'b0;
        dat_data = '0;
        forever begin
            @(negedge clk);
            hs   = dat_valid && dat_ready;
            lowc = dat_ready && !dat_valid;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cnt = 0;
                dat_valid = 1'b0;
                continue;
            end
            if (hs && dat_src_w.size() > 0) begin
                void'(dat_src_w.pop_front());
                void'(dat_src_g.pop_front());
                cnt = 0;
            end else if (lowc) begin
                cnt++;
            end
            if (dat_src_w.size() == 0) begin
                cnt = 0;
                dat_valid = 1'b0;
            end else begin
                dat_data  = dat_src_w[0];
                dat_valid = (cnt >= dat_src_g[0]);
            end
        end
    end

    // Serializer model: ser_done 20 cycles after ser_valid, optional stall after early preambles.
    initial begin
        bit s_sv;
        bit s_fd;
        bit sbusy;
        int cnt;
        int stall_left;
        int launch_no;
        ser_ready = 1'b1;
        ser_done = 1'b0;
        sbusy = 1'b0;
        cnt = 0;
        stall_left = 0;
        launch_no = 0;
        forever begin
            @(negedge clk);
            s_sv = ser_valid;
            s_fd = frame_done;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                ser_ready = 1'b1;
                ser_done = 1'b0;
                sbusy = 1'b0;
                stall_left = 0;
                launch_no = 0;
                continue;
            end
            if (s_fd) launch_no = 0;
            if (ser_done) begin
                ser_done = 1'b0;
                if (stall_left == 0) ser_ready = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) ser_ready = 1'b1;
            end
            if (s_sv) begin
                sbusy = 1'b1;
                cnt = 1;
                ser_ready = 1'b0;
                launch_no++;
            end else if (sbusy) begin
                cnt++;
                if (cnt == SER_LAT) begin
                    ser_done = 1'b1;
                    sbusy = 1'b0;
                    stall_left = (launch_no < NUM_PRE) ? stall_cfg : 0;
                end
            end
        end
    end

    // Monitor: pops expected launches and frame results as the DUT presents them.
    initial begin
        bit prev_hs;
        bit holding;
        logic [SYM_W-1:0] hold_word;
        logic [SYM_W-1:0] w;
        prev_hs = 1'b0;
        holding = 1'b0;
        hold_word = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_hs = 1'b0;
                holding = 1'b0;
                continue;
            end
            if (!ser_ready && (pre_valid || dat_valid)) begin
                chk("ready_while_ser_busy", {pre_ready, dat_ready}, 0);
            end
            if (ser_valid) begin
                chk("launch_follows_accept", prev_hs, 1);
                chk("launch_expected", exp_launch_q.size() > 0, 1);
                if (exp_launch_q.size() > 0) begin
                    w = exp_launch_q.pop_front();
                    chk("launch_word", ser_data, w);
                    hold_word = w;
                    holding = 1'b1;
                    launches_seen++;
                end
            end else if (holding) begin
                chk("ser_data_hold", ser_data, hold_word);
            end
            if (holding && ser_done) holding = 1'b0;
            if (frame_done) begin
                chk("frame_done_expected", exp_cnt_q.size() > 0, 1);
                chk("busy_at_frame_end", busy, 1);
                if (exp_cnt_q.size() > 0) begin
                    chk("final_sym_count", sym_count, exp_cnt_q.pop_front());
                    chk("final_frame_err", frame_err, exp_err_q.pop_front());
                end
            end else begin
                chk("frame_err_without_done", frame_err, 0);
            end
            prev_hs = (pre_valid && pre_ready) || (dat_valid && dat_ready);
        end
    end

    task automatic flush_all();
        exp_launch_q.delete();
        exp_cnt_q.delete();
        exp_err_q.delete();
        pre_src_w.delete();
        pre_src_g.delete();
        dat_src_w.delete();
        dat_src_g.delete();
    endtask

    task automatic idle_checks(input int exp_sc);
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_sym_count_hold", sym_count, exp_sc);
        end
        chk("launches_all_seen", exp_launch_q.size(), 0);
        chk("frames_all_seen", exp_cnt_q.size(), 0);
    endtask

    // Builds the expected outcome from plan_gap: a data gap of LIM or more
    // aborts the frame before that symbol; everything earlier is launched.
    task automatic plan_frame(input int n);
        logic [SYM_W-1:0] w;
        int sent;
        bit ab;
        sent = 0;
        ab = 1'b0;
        for (int i = 0; i < NUM_PRE; i++) begin
            w = rand_word();
            pre_src_w.push_back(w);
            pre_src_g.push_back(int'($urandom_range(0, 3)));
            exp_launch_q.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            w = rand_word();
            dat_src_w.push_back(w);
            dat_src_g.push_back(plan_gap[i]);
            if (!ab) begin
                if (plan_gap[i] >= LIM) begin
                    ab = 1'b1;
                end else begin
                    exp_launch_q.push_back(w);
                    sent++;
                end
            end
        end
        exp_cnt_q.push_back(NUM_PRE + sent);
        exp_err_q.push_back(ab);
    endtask

    task automatic run_frame(input int n, input int stall, input bit inject, input bit mid, input bit armed);
        bit done;
        int exp_sc;
        plan_frame(n);
        exp_sc = exp_cnt_q[exp_cnt_q.size() - 1];
        stall_cfg = stall;
        if (!armed) begin
            @(posedge clk);
            #1;
            frame_start = 1'b1;
            num_data_syms = 8'(n);
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        num_data_syms = 8'($urandom);
        done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                frame_start = inject;
                num_data_syms = 8'($urandom);
                @(posedge clk);
                #1;
                frame_start = 1'b0;
                done = 1'b1;
            end else begin
                frame_start = mid && ($urandom_range(0, 15) == 0);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout actual=no_frame_done required=frame_done n=%0d", n);
            finish_now();
        end
        pre_src_w.delete();
        pre_src_g.delete();
        dat_src_w.delete();
        dat_src_g.delete();
        idle_checks(exp_sc);
    endtask

    task automatic reset_mid_frame();
        int base;
        logic [SYM_W-1:0] w;
        base = launches_seen;
        for (int i = 0; i < NUM_PRE; i++) begin
            w = rand_word();
            pre_src_w.push_back(w);
            pre_src_g.push_back(0);
            exp_launch_q.push_back(w);
        end
        for (int i = 0; i < 2; i++) begin
            dat_src_w.push_back(rand_word());
            dat_src_g.push_back(0);
        end
        stall_cfg = 0;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        num_data_syms = 8'd2;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        for (int c = 0; c < 500 && launches_seen < base + 2; c++) @(posedge clk);
        if (launches_seen < base + 2) begin
            errors++;
            $display("FAIL reset_test_timeout actual=%0d required=%0d", launches_seen - base, 2);
            finish_now();
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_sym_count", sym_count, 1);
        chk("pre_reset_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sym_count", sym_count, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_frame_done", frame_done, 0);
        flush_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        idle_checks(0);
    endtask

    initial begin
        reset_n = 1'b0;
        frame_start = 1'b0;
        num_data_syms = '0;
        #3;
        chk("reset_ser_valid", ser_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sym_count", sym_count, 0);
        chk("reset_ser_data", ser_data, 0);
        chk("reset_ready", {pre_ready, dat_ready}, 0);
        repeat (3) @(posedge clk);

        // First frame is requested while reset is still asserted.
        for (int i = 0; i < 3; i++) plan_gap[i] = 0;
        frame_start = 1'b1;
        num_data_syms = 8'd3;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        run_frame(3, 0, 1'b0, 1'b0, 1'b1);

        run_frame(0, 0, 1'b0, 1'b0, 1'b0);

        plan_gap[0] = 0;
        plan_gap[1] = 64;
        plan_gap[2] = 0;
        run_frame(3, 0, 1'b0, 1'b0, 1'b0);

        plan_gap[0] = 63;
        plan_gap[1] = 0;
        run_frame(2, 5, 1'b1, 1'b1, 1'b0);

        reset_mid_frame();

        for (int i = 0; i < 4; i++) plan_gap[i] = int'($urandom_range(0, 3));
        run_frame(4, 0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 18; k++) begin
            int n;
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       plan_gap[i] = 62;
                        1:       plan_gap[i] = 63;
                        2:       plan_gap[i] = 64;
                        default: plan_gap[i] = 70;
                    endcase
                end else begin
                    plan_gap[i] = int'($urandom_range(0, 6));
                end
            end
            run_frame(n,
                      ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'b0);
        end

        repeat (5) @(posedge clk);
        finish_now();
    end

endmodule

// File: doc/ofdm_symbol_scheduler.md
OFDM_SYMBOL_SCHEDULER -- requirements
Module: ofdm_symbol_scheduler

Interface
REQ-001 Parameter: SYM_W, 304, width of one OFDM symbol word handed to the 304-to-16 serializer.
REQ-002 Parameter: NUM_PRE, 2, preamble symbols sent at the start of every frame (range 1..15).
REQ-003 Parameter: UNDERRUN_LIM, 64, maximum cycles spent waiting for a data symbol before the frame is aborted.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 frame_start  in  1  single-cycle request to begin a frame.
REQ-008 num_data_syms  in  8  data symbols in the frame; sampled only on an accepted frame_start.
REQ-009 pre_valid / pre_data  in  1 / SYM_W  preamble source word and its valid flag.
REQ-010 pre_ready  out  1  scheduler accepts pre_data this cycle.
REQ-011 dat_valid / dat_data  in  1 / SYM_W  data-symbol source word and its valid flag.
REQ-012 dat_ready  out  1  scheduler accepts dat_data this cycle.
REQ-013 ser_ready / ser_done  in  1 / 1  serializer idle flag and its one-cycle symbol-complete pulse.
REQ-014 ser_valid  out  1  one-cycle launch pulse to the serializer.
REQ-015 ser_data  out  SYM_W  symbol word driven to the serializer.
REQ-016 busy  out  1  high from the frame_start acceptance until the FRAME_END cycle, inclusive.
REQ-017 frame_done / frame_err  out  1 / 1  one-cycle end-of-frame pulse; frame_err is high on the same cycle when the frame was aborted.
REQ-018 sym_count  out  8  symbols completed in the current frame, counting preamble and data.

Function
REQ-019 The states SHALL be IDLE, PRE_WAIT, DAT_WAIT, XMIT and FRAME_END.
REQ-020 IDLE: frame_start SHALL latch num_data_syms, clear sym_count and the preamble counter, and move to PRE_WAIT on the next edge.
REQ-021 frame_start SHALL be ignored in every state except IDLE.
REQ-022 pre_ready SHALL equal (state==PRE_WAIT) && ser_ready, and dat_ready SHALL equal (state==DAT_WAIT) && ser_ready; both are combinational decodes.
REQ-023 A source word SHALL be accepted when valid && ready: the edge loads ser_data, sets ser_valid for exactly the next cycle, and enters XMIT.
REQ-024 ser_data SHALL stay unchanged from the load edge until the edge after ser_done, because the serializer slices data_in live for 19 cycles.
REQ-025 XMIT: on ser_done, sym_count SHALL increment by 1; ser_done outside XMIT SHALL be ignored.
REQ-026 From XMIT the next state SHALL be PRE_WAIT while preambles sent < NUM_PRE, otherwise DAT_WAIT while data sent < the latched count, otherwise FRAME_END.
REQ-027 If the latched num_data_syms is 0, the last preamble's ser_done SHALL go directly to FRAME_END.
REQ-028 DAT_WAIT timeout:
- an 8-bit wait counter SHALL count cycles with dat_valid low, and reset on entry to DAT_WAIT;
- on reaching UNDERRUN_LIM the FSM SHALL go to FRAME_END with frame_err set;
- PRE_WAIT has no timeout.
REQ-029 FRAME_END SHALL last one cycle: frame_done=1, frame_err as determined, then IDLE.
REQ-030 A frame_start arriving in the FRAME_END cycle SHALL be ignored.
REQ-031 sym_count SHALL hold its final value in IDLE until the next accepted frame_start.
REQ-032 Both ready outputs SHALL stay low when the source is valid but ser_ready=0; no word is accepted in that case.

Reset
REQ-033 Asserting reset_n low SHALL immediately force:
- state=IDLE;
- ser_valid, frame_done, frame_err and busy to 0;
- sym_count, ser_data and all internal counters to 0.
REQ-034 Reset mid-frame SHALL discard the frame with no frame_done pulse.
REQ-035 The first frame_start is accepted on the first rising edge after reset_n deasserts.

Verification
REQ-036 num_data_syms=3, sources always valid, serializer model with done 20 cycles after valid_in -> 5 ser_valid pulses (2 pre, 3 data), sym_count=5, frame_done=1, frame_err=0.
REQ-037 num_data_syms=0 -> exactly 2 launches, then FRAME_END and sym_count=2.
REQ-038 After the 1st data symbol, dat_valid is held low for 64 cycles -> frame_done=1, frame_err=1, sym_count=3, no further ser_valid.
REQ-039 ser_data sampled on every cycle between launch and ser_done -> constant and equal to the accepted word; frame_start pulsed mid-frame -> no effect.
REQ-040 ser_ready=0 while pre_valid=1 -> pre_ready=0; when ser_ready rises -> acceptance on that cycle and ser_valid on the next.
REQ-041 reset_n pulsed low during XMIT of the 2nd symbol -> outputs cleared immediately, no frame_done, and a new frame runs normally afterwards.
